acl2_sample_reader: RTL and testbench

Hardware sequencer that sits directly upstream of the SPI core and autonomously performs ADXL362 burst reads of XDATA_L..TEMP_H (0x0E..0x15). It drives the core's register-level write FIFO, drains its read FIFO, owns chip select, and presents one coherent X/Y/Z/temperature sample set. This frees the Picoblaze from byte-level SPI traffic.

---
 rtl/acl2_pkg.sv | 50 +++++
 rtl/acl2_sample_reader.sv | 202 ++++++++++++++++++++
 tb/tb_acl2_sample_reader.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acl2_pkg.sv
// Shared constants and types for the ADXL362 sample reader: command and
// register codes, SPI core status bit positions, FSM states and the sample set.
package acl2_pkg;

    // ADXL362 command bytes and register addresses
    localparam logic [7:0] ADXL_CMD_WRITE   = 8'h0A;
    localparam logic [7:0] ADXL_CMD_READ    = 8'h0B;
    localparam logic [7:0] ADXL_REG_XDATA_L = 8'h0E;
    localparam logic [7:0] ADXL_REG_TEMP_L  = 8'h14;

    // Burst shape: command + address, then XDATA_L..TEMP_H
    localparam int unsigned NUM_BYTES = 8;
    localparam int unsigned BURST_LEN = NUM_BYTES + 2;
    localparam int unsigned BURST_CW  = $clog2(BURST_LEN + 1);

    // SPI core status register bit positions
    localparam int unsigned SPSR_WFFULL  = 3;
    localparam int unsigned SPSR_WFEMPTY = 2;
    localparam int unsigned SPSR_RFFULL  = 1;
    localparam int unsigned SPSR_RFEMPTY = 0;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CS_SETUP = 3'd1,
        ST_XFER     = 3'd2,
        ST_CS_HOLD  = 3'd3,
        ST_FINISH   = 3'd4
    } acl2_state_e;

    // One coherent sample set, each field a raw {H,L} register pair
    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic [15:0] t;
    } acl2_sample_t;

    // Byte pushed to the write FIFO at burst position idx: command, start
    // address, then dummy bytes that clock the register contents out.
    function automatic logic [7:0] burst_tx_byte(input logic [BURST_CW-1:0] idx);
        logic [7:0] b;
        b = 8'h00;
        if (idx == BURST_CW'(0))
            b = ADXL_CMD_READ;
        else if (idx == BURST_CW'(1))
            b = ADXL_REG_XDATA_L;
        return b;
    endfunction

endpackage

// File: rtl/acl2_sample_reader.sv
// Autonomous ADXL362 burst reader. Pushes the read command, start address and
// dummy bytes into the SPI core write FIFO, drains the read FIFO into a staging
// array, and publishes X/Y/Z/temperature atomically when the burst completes.
// wfwe/rfre/wfdin are decoded combinationally from the current state and the
// core status so the core sees each strobe in the same cycle it is decided.
module acl2_sample_reader
    import acl2_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CS_SETUP   = 4,
    parameter int unsigned CS_HOLD    = 4,
    parameter int unsigned TIMEOUT    = 16'hFFFF
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        ncs_o,
    output logic        wfwe,
    output logic [7:0]  wfdin,
    output logic        rfre,
    input  logic [7:0]  rfdout,
    input  logic [7:0]  spsr,
    output logic [15:0] x_data,
    output logic [15:0] y_data,
    output logic [15:0] z_data,
    output logic [15:0] temperature
);

    // Phase counter covers both chip-select guard intervals
    localparam int unsigned PMAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned PW   = (PMAX > 2) ? $clog2(PMAX) : 1;
    localparam int unsigned WW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned SW   = $clog2(NUM_BYTES);

    typedef logic [BURST_CW-1:0] cnt_t;
    typedef logic [PW-1:0]       phase_t;
    typedef logic [WW-1:0]       wd_t;
    typedef logic [SW-1:0]       sidx_t;

    localparam cnt_t   BURST_C    = cnt_t'(BURST_LEN);
    localparam cnt_t   LAST_RX    = cnt_t'(BURST_LEN - 1);
    // A depth at or beyond the burst length never limits; avoid truncation
    localparam cnt_t   DEPTH_C    = (FIFO_DEPTH >= BURST_LEN) ? cnt_t'(BURST_LEN)
                                                               : cnt_t'(FIFO_DEPTH);
    localparam phase_t SETUP_LAST = phase_t'(CS_SETUP - 1);
    localparam phase_t HOLD_LAST  = phase_t'(CS_HOLD - 1);
    localparam wd_t    WD_LAST    = wd_t'(TIMEOUT - 1);

    acl2_state_e                  state_q, state_d;
    phase_t                       phase_q, phase_d;
    cnt_t                         tx_cnt_q, tx_cnt_d;
    cnt_t                         rx_cnt_q, rx_cnt_d;
    wd_t                          wd_q, wd_d;
    logic                         busy_q, busy_d;
    logic                         done_q, done_d;
    logic                         err_q, err_d;
    logic                         ncs_q, ncs_d;
    logic [NUM_BYTES-1:0][7:0]    stage_q, stage_d;
    acl2_sample_t                 sample_q, sample_d;

    cnt_t                         outstanding;
    logic                         push;
    logic                         pop;

    // Push/pop decode; the outstanding bound keeps the read FIFO from overflowing
    always_comb begin
        outstanding = tx_cnt_q - rx_cnt_q;
        push = (state_q == ST_XFER) && (tx_cnt_q < BURST_C) &&
               !spsr[SPSR_WFFULL] && (outstanding < DEPTH_C);
        pop  = (state_q == ST_XFER) && !spsr[SPSR_RFEMPTY];
    end

    // Sequencer next state: chip-select guards, transfer, timeout abort, publish
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        wd_d     = wd_q;
        busy_d   = busy_q;
        ncs_d    = ncs_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        stage_d  = stage_q;
        sample_d = sample_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_CS_SETUP;
                    busy_d   = 1'b1;
                    ncs_d    = 1'b0;
                    phase_d  = '0;
                    tx_cnt_d = '0;
                    rx_cnt_d = '0;
                    wd_d     = '0;
                end
            end

            ST_CS_SETUP: begin
                if (phase_q == SETUP_LAST)
                    state_d = ST_XFER;
                else
                    phase_d = phase_q + phase_t'(1);
            end

            ST_XFER: begin
                if (push)
                    tx_cnt_d = tx_cnt_q + cnt_t'(1);
                if (pop) begin
                    rx_cnt_d = rx_cnt_q + cnt_t'(1);
                    wd_d     = '0;
                    // Command and address slots return junk; keep data only
                    if (rx_cnt_q >= cnt_t'(2))
                        stage_d[sidx_t'(rx_cnt_q - cnt_t'(2))] = rfdout;
                    if (rx_cnt_q == LAST_RX) begin
                        state_d = ST_CS_HOLD;
                        phase_d = '0;
                    end
                end else if (wd_q == WD_LAST) begin
                    // Slave went silent: abandon the burst, keep old samples
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    ncs_d   = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + wd_t'(1);
                end
            end

            ST_CS_HOLD: begin
                if (phase_q == HOLD_LAST) begin
                    state_d    = ST_FINISH;
                    ncs_d      = 1'b1;
                    done_d     = 1'b1;
                    sample_d.x = {stage_q[1], stage_q[0]};
                    sample_d.y = {stage_q[3], stage_q[2]};
                    sample_d.z = {stage_q[5], stage_q[4]};
                    sample_d.t = {stage_q[7], stage_q[6]};
                end else begin
                    phase_d = phase_q + phase_t'(1);
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                ncs_d   = 1'b1;
            end
        endcase
    end

    // State registers; reset drops chip select and clears every output
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= ST_IDLE;
            phase_q  <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            wd_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            ncs_q    <= 1'b1;
            stage_q  <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            ncs_q    <= ncs_d;
            stage_q  <= stage_d;
            sample_q <= sample_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = err_q;
    assign ncs_o       = ncs_q;
    assign wfwe        = push;
    assign wfdin       = push ? burst_tx_byte(tx_cnt_q) : 8'h00;
    assign rfre        = pop;
    assign x_data      = sample_q.x;
    assign y_data      = sample_q.y;
    assign z_data      = sample_q.z;
    assign temperature = sample_q.t;

endmodule

// File: tb/tb_acl2_sample_reader.sv
// Bench for acl2_sample_reader: SPI core model with 4-deep FIFOs and an
// ADXL362 slave answering from slv_data, table of bursts plus corner sequences.
module tb_acl2_sample_reader;
    import acl2_pkg::*;

    localparam int SHIFT   = 8;   // clk cycles per SPI byte in the core model
    localparam int TMO     = 64;
    localparam int SETUP_T = 4;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, error, ncs_o, wfwe, rfre;
    logic [7:0]  wfdin, rfdout, spsr;
    logic [15:0] x_data, y_data, z_data, temperature;

    always #5 clk = ~clk;

    acl2_sample_reader #(
        .FIFO_DEPTH(4), .CS_SETUP(SETUP_T), .CS_HOLD(4), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .nrst(nrst), .start(start), .busy(busy), .done(done),
        .error(error), .ncs_o(ncs_o), .wfwe(wfwe), .wfdin(wfdin), .rfre(rfre),
        .rfdout(rfdout), .spsr(spsr), .x_data(x_data), .y_data(y_data),
        .z_data(z_data), .temperature(temperature)
    );

    // ---------------- SPI core + slave model ----------------
    logic [7:0] wf_mem [4];
    logic [7:0] wf_d   [4];
    logic [7:0] rf_mem [4];
    logic [7:0] rf_d   [4];
    int         wf_n, wn_d, rf_n, rn_d, sck, sck_d, byte_idx, bidx_d;
    logic       shift_ovf;
    logic [7:0] resp;
    logic       mute = 1'b0, hide_empty = 1'b0, core_clr = 1'b1;
    logic [7:0] slv_data [8];
    logic [7:0] tx_log [16];
    int         tx_n, txc, rxc, max_out, viol, done_cnt, err_cnt;

    assign spsr   = {4'b0000, wf_n == 4, wf_n == 0, rf_n == 4, (rf_n == 0) || hide_empty};
    assign rfdout = rf_mem[0];

    always_comb begin
        wf_d = wf_mem; wn_d = wf_n; rf_d = rf_mem; rn_d = rf_n;
        sck_d = sck; bidx_d = byte_idx; shift_ovf = 1'b0; resp = 8'hEE;
        if (rfre && rn_d > 0) begin
            for (int i = 0; i < 3; i++) rf_d[i] = rf_d[i+1];
            rf_d[3] = 8'h00;
            rn_d = rn_d - 1;
        end
        if (wn_d > 0) begin
            if (sck == SHIFT - 1) begin
                if (rn_d < 4) begin
                    if (bidx_d >= 2 && bidx_d < 10) resp = slv_data[bidx_d-2];
                    if (!mute) begin
                        rf_d[rn_d] = resp;
                        rn_d = rn_d + 1;
                    end
                    for (int i = 0; i < 3; i++) wf_d[i] = wf_d[i+1];
                    wf_d[3] = 8'h00;
                    wn_d = wn_d - 1;
                    bidx_d = bidx_d + 1;
                    sck_d = 0;
                end else begin
                    shift_ovf = 1'b1;
                end
            end else begin
                sck_d = sck + 1;
            end
        end else begin
            sck_d = 0;
        end
        if (wfwe && wn_d < 4) begin
            wf_d[wn_d] = wfdin;
            wn_d = wn_d + 1;
        end
        if (ncs_o) bidx_d = 0;
        if (core_clr) begin
            wn_d = 0; rn_d = 0; sck_d = 0; bidx_d = 0;
            for (int i = 0; i < 4; i++) begin wf_d[i] = 8'h00; rf_d[i] = 8'h00; end
        end
    end

    always @(posedge clk) begin
        wf_mem <= wf_d; rf_mem <= rf_d; wf_n <= wn_d; rf_n <= rn_d;
        sck <= sck_d; byte_idx <= bidx_d;
        if (core_clr) begin
            tx_n <= 0; txc <= 0; rxc <= 0; max_out <= 0; viol <= 0;
            done_cnt <= 0; err_cnt <= 0;
        end else begin
            if (wfwe) begin
                if (tx_n < 16) tx_log[tx_n] <= wfdin;
                tx_n <= tx_n + 1;
            end
            txc <= txc + (wfwe ? 1 : 0);
            rxc <= rxc + (rfre ? 1 : 0);
            if (txc - rxc > max_out) max_out <= txc - rxc;
            viol <= viol + ((wfwe && (txc - rxc) >= 4) ? 1 : 0)
                         + ((wfwe && wf_n == 4) ? 1 : 0)
                         + ((rfre && rf_n == 0) ? 1 : 0)
                         + (shift_ovf ? 1 : 0);
            done_cnt <= done_cnt + (done ? 1 : 0);
            err_cnt  <= err_cnt + (error ? 1 : 0);
        end
    end

    // ---------------- checking helpers ----------------
    int checks = 0, failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_core();
        @(negedge clk); core_clr = 1'b1;
        @(negedge clk); core_clr = 1'b0;
    endtask

    task automatic load_slave(input logic [63:0] d);
        for (int i = 0; i < 8; i++) slv_data[i] = d[8*i +: 8];
    endtask

    // Leaves the caller at the negedge after the accepting edge
    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic wait_done(output logic seen);
        int n;
        n = 0;
        while (!done && n < 3000) begin @(negedge clk); n++; end
        seen = done;
    endtask

    task automatic check_sample(input string tag, input logic [63:0] exp);
        check({tag, "_x"}, x_data, exp[63:48]);
        check({tag, "_y"}, y_data, exp[47:32]);
        check({tag, "_z"}, z_data, exp[31:16]);
        check({tag, "_t"}, temperature, exp[15:0]);
    endtask

    typedef struct packed {
        logic [63:0] d;      // slave data, byte 0 in bits 7:0
        logic [63:0] smp;    // expected {x, y, z, t}
    } vec_t;

    vec_t vecs [3];
    logic seen;
    int   k;
    logic [7:0] exp_b;

    initial begin
        vecs[0] = '{d: 64'h1817161514131211, smp: {16'h1211, 16'h1413, 16'h1615, 16'h1817}};
        vecs[1] = '{d: 64'h55AA00007FFF8001, smp: {16'h8001, 16'h7FFF, 16'h0000, 16'h55AA}};
        vecs[2] = '{d: 64'hBEBAFECAEFBEADDE, smp: {16'hADDE, 16'hEFBE, 16'hFECA, 16'hBEBA}};

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ctl {busy,done,err,ncs,wfwe,rfre}", {busy, done, error, ncs_o, wfwe, rfre}, 6'b000100);
        check("rst_wfdin", wfdin, 8'h00);
        check_sample("rst", 64'h0);
        nrst = 1'b1;
        core_clr = 1'b0;

        // Start timing: busy/ncs one edge after accept, first push CS_SETUP edges later
        clear_core();
        load_slave(vecs[0].d);
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        check("accept_busy", busy, 1'b1);
        check("accept_ncs", ncs_o, 1'b0);
        @(negedge clk); start = 1'b0;
        k = 0;
        while (!wfwe && k < 50) begin @(negedge clk); k++; end
        check("first_wfwe_delay", k, SETUP_T);
        check("first_wfdin", wfdin, 8'h0B);
        wait_done(seen);
        check("t0_done_seen", seen, 1'b1);
        check("t0_done_ncs", ncs_o, 1'b1);
        @(negedge clk);
        check("t0_done_pulse", done, 1'b0);
        check("t0_idle_busy", busy, 1'b0);

        // Table of bursts: samples, single done, write-FIFO byte stream
        for (int v = 0; v < 3; v++) begin
            clear_core();
            load_slave(vecs[v].d);
            pulse_start();
            wait_done(seen);
            check("tbl_done_seen", seen, 1'b1);
            check_sample("tbl", vecs[v].smp);
            @(negedge clk);
            check("tbl_done_cnt", done_cnt, 1);
            check("tbl_tx_n", tx_n, 10);
            for (int j = 0; j < 10; j++) begin
                exp_b = (j == 0) ? 8'h0B : (j == 1) ? 8'h0E : 8'h00;
                check("tbl_wfdin_seq", tx_log[j], exp_b);
            end
            check("tbl_viol", viol, 0);
        end

        // Read FIFO held full: outstanding must stop at 4
        clear_core();
        load_slave(vecs[1].d);
        hide_empty = 1'b1;
        pulse_start();
        repeat (48) @(negedge clk);
        check("stall_rf_full", rf_n, 4);
        check("stall_pushes", txc, 4);
        check("stall_max_out", max_out, 4);
        hide_empty = 1'b0;
        wait_done(seen);
        check("stall_done_seen", seen, 1'b1);
        check_sample("stall", vecs[1].smp);
        check("stall_viol", viol, 0);

        // start during XFER is ignored, not queued
        clear_core();
        load_slave(vecs[2].d);
        pulse_start();
        repeat (30) @(negedge clk);
        pulse_start();
        wait_done(seen);
        check("ign_done_seen", seen, 1'b1);
        check_sample("ign", vecs[2].smp);
        repeat (60) @(negedge clk);
        check("ign_done_cnt", done_cnt, 1);
        check("ign_busy", busy, 1'b0);

        // Silent slave: error after TIMEOUT cycles without a pop, samples kept
        clear_core();
        mute = 1'b1;
        pulse_start();
        k = 0;
        while (!wfwe && k < 50) begin @(negedge clk); k++; end
        k = 0;
        while (!error && k < 500) begin @(negedge clk); k++; end
        check("tmo_cycles", k, TMO);
        check("tmo_ncs", ncs_o, 1'b1);
        check("tmo_busy", busy, 1'b0);
        check_sample("tmo", vecs[2].smp);
        @(negedge clk);
        check("tmo_err_pulse", error, 1'b0);
        check("tmo_err_cnt", err_cnt, 1);
        check("tmo_done_cnt", done_cnt, 0);
        mute = 1'b0;

        // nrst mid-XFER, then a clean burst
        clear_core();
        load_slave(vecs[0].d);
        pulse_start();
        repeat (30) @(negedge clk);
        nrst = 1'b0;
        #1;
        check("mid_rst_ctl", {busy, done, error, ncs_o, wfwe, rfre}, 6'b000100);
        check("mid_rst_wfdin", wfdin, 8'h00);
        check_sample("mid_rst", 64'h0);
        @(negedge clk); nrst = 1'b1;
        clear_core();
        pulse_start();
        wait_done(seen);
        check("post_rst_done_seen", seen, 1'b1);
        check_sample("post_rst", vecs[0].smp);

        // Back-to-back: restart right after done with new slave data
        clear_core();
        load_slave(vecs[1].d);
        pulse_start();
        wait_done(seen);
        check("b2b_first_seen", seen, 1'b1);
        check_sample("b2b_first", vecs[1].smp);
        load_slave(vecs[2].d);
        @(negedge clk);
        check("b2b_gap_ncs", ncs_o, 1'b1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("b2b_accept_busy", busy, 1'b1);
        check("b2b_accept_ncs", ncs_o, 1'b0);
        wait_done(seen);
        check("b2b_second_seen", seen, 1'b1);
        check_sample("b2b_second", vecs[2].smp);
        @(negedge clk);
        check("b2b_done_cnt", done_cnt, 2);
        check("b2b_viol", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
